// File: rtl/clk_en_gen_pkg.sv
// Shared defaults and the per-channel configuration record for the clock-enable generator.
// The record's divisor field is sized by DIV_W_DEF, so the top-level DIV_W must track it.
package clk_en_gen_pkg;

  localparam int NUM_CH_DEF = 3;
  localparam int DIV_W_DEF  = 8;
  localparam int CH_W_DEF   = 2;

  typedef struct packed {
    logic                 en;
    logic [DIV_W_DEF-1:0] div;
  } ch_cfg_t;

  // A programmed half-period of zero behaves exactly like a half-period of one.
  function automatic logic [DIV_W_DEF-1:0] effDiv(input logic [DIV_W_DEF-1:0] div);
    return (div == '0) ? DIV_W_DEF'(1) : div;
  endfunction

endpackage

// File: rtl/clk_en_gen_ch.sv
// One divided-clock channel: a half-period counter, a level register and a
// shadow configuration that is only applied at a full-period boundary or on sync.
module clk_en_ch
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic             wr_en_i,
  input  logic             sync_i,
  output logic             div_clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  ch_cfg_t          actCfg_q,   actCfg_d;
  ch_cfg_t          pendCfg_q,  pendCfg_d;
  logic             pendFlag_q, pendFlag_d;
  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic             level_q,    level_d;
  logic             tick_q,     tick_d;

  ch_cfg_t          wrCfg;
  logic [DIV_W-1:0] halfPeriod;
  logic             boundary;

  assign wrCfg      = '{en: wr_en_i, div: wr_div_i};
  assign halfPeriod = effDiv(actCfg_q.div);
  assign boundary   = actCfg_q.en && (cnt_q == halfPeriod - DIV_W'(1));

  // Sync wins over normal counting; a write arriving with sync bypasses the shadow.
  // Otherwise a boundary falling edge applies the older shadow value before the
  // same-cycle write refills it, so the newer write stays pending.
  always_comb begin
    actCfg_d   = actCfg_q;
    pendCfg_d  = pendCfg_q;
    pendFlag_d = pendFlag_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    tick_d     = 1'b0;

    if (sync_i) begin
      cnt_d   = '0;
      level_d = 1'b0;
      if (wr_i) begin
        actCfg_d   = wrCfg;
        pendFlag_d = 1'b0;
      end else if (pendFlag_q) begin
        actCfg_d   = pendCfg_q;
        pendFlag_d = 1'b0;
      end
    end else begin
      if (boundary) begin
        cnt_d   = '0;
        level_d = ~level_q;
        tick_d  = 1'b1;
        if (level_q && pendFlag_q) begin
          actCfg_d   = pendCfg_q;
          pendFlag_d = 1'b0;
        end
      end else if (actCfg_q.en) begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      if (wr_i) begin
        if (!actCfg_q.en) begin
          actCfg_d   = wrCfg;
          cnt_d      = '0;
          level_d    = 1'b0;
          pendFlag_d = 1'b0;
        end else begin
          pendCfg_d  = wrCfg;
          pendFlag_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      actCfg_q   <= '{en: 1'b0, div: DIV_W'(1)};
      pendCfg_q  <= '{en: 1'b0, div: DIV_W'(1)};
      pendFlag_q <= 1'b0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      actCfg_q   <= actCfg_d;
      pendCfg_q  <= pendCfg_d;
      pendFlag_q <= pendFlag_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      tick_q     <= tick_d;
    end
  end

  assign div_clk_o = level_q;
  assign tick_o    = tick_q;
  assign pending_o = pendFlag_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel divided-clock generator: decodes configuration writes to one
// channel each and fans the global sync out to every channel.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  // Writes to a channel index with no instance simply match nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic chWr;
    assign chWr = cfg_wr && (cfg_ch == CH_W'(i));

    clk_en_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (chWr),
      .wr_div_i (cfg_div),
      .wr_en_i  (cfg_en),
      .sync_i   (sync_all),
      .div_clk_o(div_clk[i]),
      .tick_o   (tick[i]),
      .pending_o(pending[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: a vector table for bring-up and reconfiguration,
// then hand-written sequences for disable, div=0, sync and mid-period reset.
module tb_clk_en_gen;

  logic       clk;
  logic       rst_n;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       sync_all;
  logic [2:0] div_clk;
  logic [2:0] tick;
  logic [2:0] pending;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic       rstN;
    logic       wr;
    logic [1:0] ch;
    logic [7:0] div;
    logic       en;
    logic       sync;
    logic [2:0] expClk;
    logic [2:0] expTick;
    logic [2:0] expPend;
  } vec_t;

  vec_t vecs[19];

  clk_en_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_en  (cfg_en),
    .sync_all(sync_all),
    .div_clk (div_clk),
    .tick    (tick),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs, take the edge, and leave outputs settled for sampling.
  task automatic applyStimulus(input logic r, input logic w, input logic [1:0] ch,
                               input logic [7:0] dv, input logic e, input logic s);
    rst_n    = r;
    cfg_wr   = w;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_en   = e;
    sync_all = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  function automatic vec_t mkVec(logic r, logic w, logic [1:0] ch, logic [7:0] dv, logic e,
                                 logic s, logic [2:0] c, logic [2:0] t, logic [2:0] p);
    vec_t v;
    v.rstN = r; v.wr = w; v.ch = ch; v.div = dv; v.en = e; v.sync = s;
    v.expClk = c; v.expTick = t; v.expPend = p;
    return v;
  endfunction

  initial begin
    // ch0 brought up at div=3, reprogrammed to div=5 mid-high, plus an out-of-range write
    vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[1]  = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[2]  = mkVec(1, 1, 0, 3, 1, 0, 3'b000, 3'b000, 3'b000);
    vecs[3]  = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[4]  = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[5]  = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    vecs[6]  = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    vecs[7]  = mkVec(1, 1, 0, 5, 1, 0, 3'b001, 3'b000, 3'b001);
    vecs[8]  = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b001, 3'b000);
    vecs[9]  = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[10] = mkVec(1, 1, 3, 1, 1, 0, 3'b000, 3'b000, 3'b000);
    vecs[11] = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[12] = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[13] = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    vecs[14] = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    vecs[15] = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    vecs[16] = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    vecs[17] = mkVec(1, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    vecs[18] = mkVec(1, 0, 0, 0, 0, 0, 3'b000, 3'b001, 3'b000);

    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0; sync_all = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].wr, vecs[i].ch, vecs[i].div, vecs[i].en, vecs[i].sync);
      checkOutput($sformatf("vec%0d div_clk", i), div_clk, vecs[i].expClk);
      checkOutput($sformatf("vec%0d tick", i), tick, vecs[i].expTick);
      checkOutput($sformatf("vec%0d pending", i), pending, vecs[i].expPend);
    end

    // ch1 div=4 disabled mid-high: finishes its period, then stays quiet
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("dis low phase", div_clk, 3'b000);
    end
    idleCycle();
    checkOutput("dis rise clk", div_clk, 3'b010);
    checkOutput("dis rise tick", tick, 3'b010);
    applyStimulus(1, 1, 1, 4, 0, 0);
    checkOutput("dis pending", pending, 3'b010);
    idleCycle();
    idleCycle();
    checkOutput("dis still pending", pending, 3'b010);
    idleCycle();
    checkOutput("dis fall clk", div_clk, 3'b000);
    checkOutput("dis fall tick", tick, 3'b010);
    checkOutput("dis fall pending", pending, 3'b000);
    for (int i = 0; i < 20; i++) begin
      idleCycle();
      checkOutput("dis quiet clk", div_clk, 3'b000);
      checkOutput("dis quiet tick", tick, 3'b000);
    end

    // ch2 div=0 toggles every cycle with tick held high
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] expC;
      idleCycle();
      expC = (i % 2 == 0) ? 3'b100 : 3'b000;
      checkOutput("div0 clk", div_clk, expC);
      checkOutput("div0 tick", tick, 3'b100);
    end

    // ch0 div=2 and ch1 div=3 out of phase, then sync realigns them
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 2, 1, 0);
    idleCycle();
    applyStimulus(1, 1, 1, 3, 1, 0);
    checkOutput("sync pre ch0 rise", div_clk, 3'b001);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("sync pre phase clk", div_clk, 3'b010);
    checkOutput("sync pre phase tick", tick, 3'b010);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("sync clk", div_clk, 3'b000);
    checkOutput("sync tick", tick, 3'b000);
    idleCycle();
    checkOutput("sync+1 clk", div_clk, 3'b000);
    idleCycle();
    checkOutput("sync+2 clk", div_clk, 3'b001);
    checkOutput("sync+2 tick", tick, 3'b001);
    idleCycle();
    checkOutput("sync+3 clk", div_clk, 3'b011);
    checkOutput("sync+3 tick", tick, 3'b010);

    // write coinciding with sync on a running channel applies at once
    applyStimulus(1, 1, 1, 1, 1, 1);
    checkOutput("syncwr clk", div_clk, 3'b000);
    checkOutput("syncwr pending", pending, 3'b000);
    idleCycle();
    checkOutput("syncwr+1 clk", div_clk, 3'b010);
    checkOutput("syncwr+1 tick", tick, 3'b010);

    // reset mid-high with a write pending, overriding a same-cycle write and sync
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 3, 1, 0);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("rst pre rise", div_clk, 3'b001);
    applyStimulus(1, 1, 0, 5, 1, 0);
    checkOutput("rst pre pending", pending, 3'b001);
    applyStimulus(0, 1, 1, 1, 1, 1);
    checkOutput("rst clk", div_clk, 3'b000);
    checkOutput("rst tick", tick, 3'b000);
    checkOutput("rst pending", pending, 3'b000);
    for (int i = 0; i < 12; i++) begin
      idleCycle();
      checkOutput("post rst clk", div_clk, 3'b000);
      checkOutput("post rst tick", tick, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
